// File: rtl/queue_ctrl_2x111_pkg.sv
// Shared sizing helpers and default geometry for the ready/valid queue family.
package queue_pkg;

    localparam int QUEUE_DEPTH_DEFAULT = 2;
    localparam int QUEUE_WIDTH_DEFAULT = 111;

    // A single-entry queue still needs a 1-bit pointer; it is tied to zero.
    function automatic int PtrW(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int CountW(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/queue_ctrl_2x111_if.sv
// Enqueue/dequeue handshake bundle; master is the producer/consumer side, slave is the queue.
interface queue_ctrl_2x111_if
    import queue_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter int WIDTH = QUEUE_WIDTH_DEFAULT
);
    logic                       io_enq_ready;
    logic                       io_enq_valid;
    logic [WIDTH-1:0]           io_enq_bits;
    logic                       io_deq_ready;
    logic                       io_deq_valid;
    logic [WIDTH-1:0]           io_deq_bits;
    logic [CountW(DEPTH)-1:0]   io_count;

    modport master (
        input  io_enq_ready, io_deq_valid, io_deq_bits, io_count,
        output io_enq_valid, io_enq_bits, io_deq_ready
    );

    modport slave (
        output io_enq_ready, io_deq_valid, io_deq_bits, io_count,
        input  io_enq_valid, io_enq_bits, io_deq_ready
    );
endinterface

// File: rtl/queue_ctrl_2x111_ram.sv
// Two-port storage array: posedge write port, combinational read port. Holds no control state.
module ram_2x111
    import queue_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter int WIDTH = QUEUE_WIDTH_DEFAULT
) (
    input  logic [PtrW(DEPTH)-1:0] R0_addr,
    input  logic                   R0_en,
    input  logic                   R0_clk,
    output logic [WIDTH-1:0]       R0_data,
    input  logic [PtrW(DEPTH)-1:0] W0_addr,
    input  logic                   W0_en,
    input  logic                   W0_clk,
    input  logic [WIDTH-1:0]       W0_data
);
    logic [WIDTH-1:0] mem [DEPTH];

    // The read port is asynchronous, so its clock has nothing to time.
    logic unused_r0_clk;
    assign unused_r0_clk = R0_clk;

    // NOTE: the array has no reset; validity is tracked by the controller, and
    // a resettable memory would prevent mapping onto RAM macros.
    always_ff @(posedge W0_clk) begin
        if (W0_en) begin
            mem[W0_addr] <= W0_data;
        end
    end

    assign R0_data = R0_en ? mem[R0_addr] : '0;
endmodule

// File: rtl/queue_ctrl_2x111.sv
// Decoupled FIFO controller: pointers, full/empty tracking and the handshake around a 1R/1W array.
module queue_ctrl_2x111
    import queue_pkg::*;
#(
    parameter int DEPTH = QUEUE_DEPTH_DEFAULT,
    parameter int WIDTH = QUEUE_WIDTH_DEFAULT,
    parameter bit PIPE  = 1'b0,
    parameter bit FLOW  = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    queue_ctrl_2x111_if.slave  io
);
    localparam int PW = PtrW(DEPTH);
    localparam int CW = CountW(DEPTH);

    logic [PW-1:0]    enq_ptr;
    logic [PW-1:0]    deq_ptr;
    logic             maybe_full;
    logic             ptr_match;
    logic             empty;
    logic             full;
    logic             do_enq;
    logic             do_deq;
    logic             w0_en;
    logic [WIDTH-1:0] r0_data;

    // Explicit wrap so non-power-of-2 depths never index past the last entry.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign ptr_match = (enq_ptr == deq_ptr);
    assign empty     = ptr_match & ~maybe_full;
    assign full      = ptr_match & maybe_full;

    // NOTE: every output of this block gets a default first, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        io.io_enq_ready = ~full | (PIPE & io.io_deq_ready);
        io.io_deq_valid = ~empty;
        io.io_deq_bits  = r0_data;
        do_enq          = io.io_enq_ready & io.io_enq_valid;
        do_deq          = 1'b0;
        if (FLOW && empty) begin
            io.io_deq_valid = io.io_enq_valid;
            io.io_deq_bits  = io.io_enq_bits;
        end
        do_deq = io.io_deq_ready & io.io_deq_valid;
        // A beat that bypasses an empty queue never touches the array.
        if (FLOW && empty && io.io_deq_ready) begin
            do_enq = 1'b0;
            do_deq = 1'b0;
        end
    end

    always_comb begin
        io.io_count = '0;
        if (ptr_match) begin
            io.io_count = maybe_full ? CW'(DEPTH) : '0;
        end else if (enq_ptr > deq_ptr) begin
            io.io_count = CW'(enq_ptr) - CW'(deq_ptr);
        end else begin
            io.io_count = CW'(DEPTH) + CW'(enq_ptr) - CW'(deq_ptr);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            enq_ptr    <= '0;
            deq_ptr    <= '0;
            maybe_full <= 1'b0;
        end else begin
            if (do_enq) begin
                enq_ptr <= next_ptr(enq_ptr);
            end
            if (do_deq) begin
                deq_ptr <= next_ptr(deq_ptr);
            end
            if (do_enq != do_deq) begin
                maybe_full <= do_enq;
            end
        end
    end

    // A beat offered during reset must not land in the array.
    assign w0_en = do_enq & ~reset;

    ram_2x111 #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_ram (
        .R0_addr (deq_ptr),
        .R0_en   (1'b1),
        .R0_clk  (clock),
        .R0_data (r0_data),
        .W0_addr (enq_ptr),
        .W0_en   (w0_en),
        .W0_clk  (clock),
        .W0_data (io.io_enq_bits)
    );
endmodule

// File: tb/tb_queue_ctrl_2x111.sv
// Directed bench for queue_ctrl_2x111: default, DEPTH=3, PIPE=1 and FLOW=1 instances.
module tb_queue_ctrl_2x111;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    queue_ctrl_2x111_if #(.DEPTH(2), .WIDTH(111)) q0 ();
    queue_ctrl_2x111_if #(.DEPTH(3), .WIDTH(111)) q3 ();
    queue_ctrl_2x111_if #(.DEPTH(2), .WIDTH(111)) qp ();
    queue_ctrl_2x111_if #(.DEPTH(2), .WIDTH(111)) qf ();

    queue_ctrl_2x111 #(.DEPTH(2), .WIDTH(111), .PIPE(1'b0), .FLOW(1'b0))
        u_base (.clock(clock), .reset(reset), .io(q0));
    queue_ctrl_2x111 #(.DEPTH(3), .WIDTH(111), .PIPE(1'b0), .FLOW(1'b0))
        u_d3   (.clock(clock), .reset(reset), .io(q3));
    queue_ctrl_2x111 #(.DEPTH(2), .WIDTH(111), .PIPE(1'b1), .FLOW(1'b0))
        u_pipe (.clock(clock), .reset(reset), .io(qp));
    queue_ctrl_2x111 #(.DEPTH(2), .WIDTH(111), .PIPE(1'b0), .FLOW(1'b1))
        u_flow (.clock(clock), .reset(reset), .io(qf));

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        step();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (q0.io_enq_ready !== 1'b1) begin
                failures++; $display("FAIL reset_enq_ready cyc=%0d got=%b exp=1", c, q0.io_enq_ready);
            end
            checks++;
            if (q0.io_deq_valid !== 1'b0) begin
                failures++; $display("FAIL reset_deq_valid cyc=%0d got=%b exp=0", c, q0.io_deq_valid);
            end
            checks++;
            if (q0.io_count !== 2'd0) begin
                failures++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", c, q0.io_count);
            end
            checks++;
            if (qf.io_deq_valid !== 1'b0 || qp.io_enq_ready !== 1'b1 || q3.io_count !== 2'd0) begin
                failures++; $display("FAIL reset_variants cyc=%0d flow_dv=%b pipe_er=%b d3_cnt=%0d exp=0/1/0",
                                     c, qf.io_deq_valid, qp.io_enq_ready, q3.io_count);
            end
            step();
        end
    endtask

    task automatic test_fill_drain();
        q0.io_enq_valid = 1'b1; q0.io_enq_bits = 111'h1; q0.io_deq_ready = 1'b0;
        #1;
        checks++;
        if (q0.io_count !== 2'd0 || q0.io_enq_ready !== 1'b1) begin
            failures++; $display("FAIL fill_start count=%0d enq_ready=%b exp=0/1", q0.io_count, q0.io_enq_ready);
        end
        step();
        q0.io_enq_bits = 111'h2;
        #1;
        checks++;
        if (q0.io_count !== 2'd1 || q0.io_deq_valid !== 1'b1 || q0.io_deq_bits !== 111'h1) begin
            failures++; $display("FAIL fill_one count=%0d dv=%b bits=%h exp=1/1/1", q0.io_count, q0.io_deq_valid, q0.io_deq_bits);
        end
        step();
        q0.io_enq_valid = 1'b0;
        #1;
        checks++;
        if (q0.io_count !== 2'd2 || q0.io_enq_ready !== 1'b0) begin
            failures++; $display("FAIL fill_full count=%0d enq_ready=%b exp=2/0", q0.io_count, q0.io_enq_ready);
        end
        step();
        q0.io_deq_ready = 1'b1;
        #1;
        checks++;
        if (q0.io_deq_valid !== 1'b1 || q0.io_deq_bits !== 111'h1) begin
            failures++; $display("FAIL drain_first dv=%b bits=%h exp=1/1", q0.io_deq_valid, q0.io_deq_bits);
        end
        step();
        #1;
        checks++;
        if (q0.io_count !== 2'd1 || q0.io_deq_bits !== 111'h2) begin
            failures++; $display("FAIL drain_second count=%0d bits=%h exp=1/2", q0.io_count, q0.io_deq_bits);
        end
        step();
        #1;
        checks++;
        if (q0.io_count !== 2'd0 || q0.io_deq_valid !== 1'b0) begin
            failures++; $display("FAIL drain_empty count=%0d dv=%b exp=0/0", q0.io_count, q0.io_deq_valid);
        end
        q0.io_deq_ready = 1'b0;
        step();
    endtask

    // Same stimulus on the DEPTH=2 and DEPTH=3 instances; both hold one beat throughout.
    task automatic test_back_to_back();
        logic [110:0] exp_bits;
        q0.io_enq_valid = 1'b1; q0.io_enq_bits = 111'd100; q0.io_deq_ready = 1'b0;
        q3.io_enq_valid = 1'b1; q3.io_enq_bits = 111'd100; q3.io_deq_ready = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            exp_bits = (i == 0) ? 111'd100 : 111'(i - 1);
            q0.io_enq_bits = 111'(i); q0.io_deq_ready = 1'b1;
            q3.io_enq_bits = 111'(i); q3.io_deq_ready = 1'b1;
            #1;
            checks++;
            if (q0.io_count !== 2'd1 || q0.io_deq_valid !== 1'b1 || q0.io_deq_bits !== exp_bits) begin
                failures++; $display("FAIL b2b_d2 i=%0d count=%0d dv=%b bits=%h exp=1/1/%h",
                                     i, q0.io_count, q0.io_deq_valid, q0.io_deq_bits, exp_bits);
            end
            checks++;
            if (q3.io_count !== 2'd1 || q3.io_deq_valid !== 1'b1 || q3.io_deq_bits !== exp_bits) begin
                failures++; $display("FAIL b2b_d3 i=%0d count=%0d dv=%b bits=%h exp=1/1/%h",
                                     i, q3.io_count, q3.io_deq_valid, q3.io_deq_bits, exp_bits);
            end
            step();
        end
        q0.io_enq_valid = 1'b0;
        q3.io_enq_valid = 1'b0;
        #1;
        checks++;
        if (q0.io_deq_bits !== 111'd9 || q3.io_deq_bits !== 111'd9) begin
            failures++; $display("FAIL b2b_last d2=%h d3=%h exp=9", q0.io_deq_bits, q3.io_deq_bits);
        end
        step();
        #1;
        checks++;
        if (q0.io_count !== 2'd0 || q3.io_count !== 2'd0) begin
            failures++; $display("FAIL b2b_empty d2=%0d d3=%0d exp=0", q0.io_count, q3.io_count);
        end
        q0.io_deq_ready = 1'b0;
        q3.io_deq_ready = 1'b0;
        step();
    endtask

    task automatic test_pipe();
        qp.io_enq_valid = 1'b1; qp.io_enq_bits = 111'h1; qp.io_deq_ready = 1'b0;
        step();
        qp.io_enq_bits = 111'h2;
        step();
        qp.io_enq_bits = 111'hAA;
        #1;
        checks++;
        if (qp.io_count !== 2'd2 || qp.io_enq_ready !== 1'b0) begin
            failures++; $display("FAIL pipe_full_stall count=%0d enq_ready=%b exp=2/0", qp.io_count, qp.io_enq_ready);
        end
        qp.io_deq_ready = 1'b1;
        #1;
        checks++;
        if (qp.io_enq_ready !== 1'b1 || qp.io_count !== 2'd2 || qp.io_deq_bits !== 111'h1) begin
            failures++; $display("FAIL pipe_pass enq_ready=%b count=%0d bits=%h exp=1/2/1",
                                 qp.io_enq_ready, qp.io_count, qp.io_deq_bits);
        end
        step();
        qp.io_enq_valid = 1'b0;
        #1;
        checks++;
        if (qp.io_count !== 2'd2 || qp.io_deq_bits !== 111'h2) begin
            failures++; $display("FAIL pipe_second count=%0d bits=%h exp=2/2", qp.io_count, qp.io_deq_bits);
        end
        step();
        #1;
        checks++;
        if (qp.io_count !== 2'd1 || qp.io_deq_bits !== 111'hAA) begin
            failures++; $display("FAIL pipe_third count=%0d bits=%h exp=1/aa", qp.io_count, qp.io_deq_bits);
        end
        step();
        #1;
        checks++;
        if (qp.io_count !== 2'd0 || qp.io_deq_valid !== 1'b0) begin
            failures++; $display("FAIL pipe_empty count=%0d dv=%b exp=0/0", qp.io_count, qp.io_deq_valid);
        end
        qp.io_deq_ready = 1'b0;
        step();
    endtask

    task automatic test_flow();
        qf.io_enq_valid = 1'b1; qf.io_enq_bits = 111'h55; qf.io_deq_ready = 1'b1;
        #1;
        checks++;
        if (qf.io_deq_valid !== 1'b1 || qf.io_deq_bits !== 111'h55 || qf.io_count !== 2'd0) begin
            failures++; $display("FAIL flow_bypass dv=%b bits=%h count=%0d exp=1/55/0",
                                 qf.io_deq_valid, qf.io_deq_bits, qf.io_count);
        end
        step();
        qf.io_enq_valid = 1'b0; qf.io_deq_ready = 1'b0;
        #1;
        checks++;
        if (qf.io_count !== 2'd0 || qf.io_deq_valid !== 1'b0) begin
            failures++; $display("FAIL flow_after count=%0d dv=%b exp=0/0", qf.io_count, qf.io_deq_valid);
        end
        qf.io_enq_valid = 1'b1; qf.io_enq_bits = 111'h66;
        step();
        qf.io_enq_valid = 1'b0;
        #1;
        checks++;
        if (qf.io_count !== 2'd1 || qf.io_deq_valid !== 1'b1 || qf.io_deq_bits !== 111'h66) begin
            failures++; $display("FAIL flow_stored count=%0d dv=%b bits=%h exp=1/1/66",
                                 qf.io_count, qf.io_deq_valid, qf.io_deq_bits);
        end
        qf.io_deq_ready = 1'b1;
        step();
        qf.io_deq_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        q0.io_enq_valid = 1'b1; q0.io_enq_bits = 111'h1; q0.io_deq_ready = 1'b0;
        step();
        q0.io_enq_bits = 111'h2;
        step();
        #1;
        checks++;
        if (q0.io_count !== 2'd2) begin
            failures++; $display("FAIL rstmid_prefill count=%0d exp=2", q0.io_count);
        end
        reset = 1'b1;
        q0.io_enq_bits = 111'h77;
        step();
        reset = 1'b0;
        q0.io_enq_valid = 1'b0;
        #1;
        checks++;
        if (q0.io_count !== 2'd0 || q0.io_deq_valid !== 1'b0 || q0.io_enq_ready !== 1'b1) begin
            failures++; $display("FAIL rstmid_cleared count=%0d dv=%b er=%b exp=0/0/1",
                                 q0.io_count, q0.io_deq_valid, q0.io_enq_ready);
        end
        q0.io_enq_valid = 1'b1; q0.io_enq_bits = 111'h3;
        step();
        q0.io_enq_valid = 1'b0; q0.io_deq_ready = 1'b1;
        #1;
        checks++;
        if (q0.io_count !== 2'd1 || q0.io_deq_bits !== 111'h3) begin
            failures++; $display("FAIL rstmid_fresh count=%0d bits=%h exp=1/3", q0.io_count, q0.io_deq_bits);
        end
        step();
        #1;
        checks++;
        if (q0.io_count !== 2'd0 || q0.io_deq_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_no_stale count=%0d dv=%b exp=0/0", q0.io_count, q0.io_deq_valid);
        end
        q0.io_deq_ready = 1'b0;
        step();
    endtask

    initial begin
        q0.io_enq_valid = 1'b0; q0.io_enq_bits = '0; q0.io_deq_ready = 1'b0;
        q3.io_enq_valid = 1'b0; q3.io_enq_bits = '0; q3.io_deq_ready = 1'b0;
        qp.io_enq_valid = 1'b0; qp.io_enq_bits = '0; qp.io_deq_ready = 1'b0;
        qf.io_enq_valid = 1'b0; qf.io_enq_bits = '0; qf.io_deq_ready = 1'b0;
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_pipe();
        test_flow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
